// File: rtl/bram_stream_pkg.sv
// Shared types and constants for the BRAM-to-stream reader.
package bram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int BUF_DEPTH = 2;
    localparam int CNTW      = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/fifo_2deep.sv
// Two-entry first-word-fall-through buffer; dout shows the oldest entry whenever count != 0.
module fifo_2deep
    import bram_stream_pkg::*;
#(
    parameter int W = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [W-1:0]    din,
    input  logic            pop,
    output logic [W-1:0]    dout,
    output logic [CNTW-1:0] count
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [W-1:0]    mem_q [BUF_DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q < CNTW'(BUF_DEPTH)) || do_pop);

    genvar gi;
    generate
        for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else if (do_push && (wr_ptr_q == PW'(gi))) begin
                    mem_q[gi] <= din;
                end
            end
        end
    endgenerate

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNTW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Streams a contiguous, wrapping run of BRAM words out as valid/ready beats with a last flag.
module bram_stream_reader
    import bram_stream_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 256,
    localparam int ADDRW = $clog2(DEPTH),
    localparam int LENW  = ADDRW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADDRW-1:0] base,
    input  logic [LENW-1:0]  len,
    output logic             busy,
    output logic             done,
    output logic [ADDRW-1:0] addr_read,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last
);

    state_t           state_q, state_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [LENW-1:0]  rem_q, rem_d;
    logic             inflight_q;
    logic             inflight_last_q;
    logic             done_q, done_d;

    logic [LENW-1:0]  len_clamped;
    logic [ADDRW-1:0] addr_next;
    logic [CNTW-1:0]  occ;
    logic [WIDTH:0]   buf_dout;
    logic [2:0]       credit_used;
    logic             pop;
    logic             issue;
    logic             issue_last;
    logic             start_ok;

    assign len_clamped = (len > LENW'(DEPTH)) ? LENW'(DEPTH) : len;
    assign addr_next   = (addr_q == ADDRW'(DEPTH - 1)) ? '0 : addr_q + ADDRW'(1);
    assign pop         = m_valid && m_ready;
    assign start_ok    = start && (state_q == IDLE);

    // Buffered words plus the one still in the BRAM pipe must fit once this cycle's pop leaves.
    assign credit_used = 3'(occ) + 3'(inflight_q);
    assign issue       = (state_q == READ) && (credit_used < (3'(BUF_DEPTH) + 3'(pop)));
    assign issue_last  = issue && (rem_q == LENW'(1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    if (len_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = READ;
                        addr_d  = base;
                        rem_d   = len_clamped;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    addr_d = addr_next;
                    rem_d  = rem_q - LENW'(1);
                    if (issue_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            inflight_q      <= issue;
            inflight_last_q <= issue_last;
            done_q          <= done_d;
        end
    end

    fifo_2deep #(
        .W (WIDTH + 1)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .din   ({inflight_last_q, data_in}),
        .pop   (pop),
        .dout  (buf_dout),
        .count (occ)
    );

    assign addr_read = addr_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign m_valid   = (occ != '0);
    assign m_data    = buf_dout[WIDTH-1:0];
    assign m_last    = m_valid && buf_dout[WIDTH];

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench: table-driven transfers, hand-written corner sequences and a randomized phase.
module tb_bram_stream_reader;

    localparam int WIDTH = 8;
    localparam int DEPTH = 256;
    localparam int ADDRW = 8;
    localparam int LENW  = 9;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [ADDRW-1:0] base = '0;
    logic [LENW-1:0]  len = '0;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             busy, done, m_valid, m_last;
    logic [ADDRW-1:0] addr_read;
    logic [WIDTH-1:0] m_data;

    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) data_in <= mem[addr_read];

    bram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base      (base),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .addr_read (addr_read),
        .data_in   (data_in),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the expected beat list is built from mem/base/len when a start is accepted.
    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    beat_t            exp_q[$];
    beat_t            b;
    logic             exp_busy = 1'b0, exp_done = 1'b0, next_busy, next_done;
    logic             rst_prev = 1'b0, stall_prev = 1'b0, stall_last, lat_armed = 1'b0;
    logic [WIDTH-1:0] stall_data;
    int               lat_cnt, cyc = 0, clamp;
    int               xfer_beats = 0, xfer_first = 0, xfer_lastd = 0;
    int               xfer_first_cyc = 0, xfer_last_cyc = 0, done_cnt = 0;

    always @(negedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            exp_q.delete();
            exp_busy   = 1'b0;
            exp_done   = 1'b0;
            stall_prev = 1'b0;
            lat_armed  = 1'b0;
            rst_prev   = 1'b1;
        end else begin
            if (rst_prev) begin
                check("reset_m_valid", m_valid, 0);
                check("reset_m_last", m_last, 0);
                check("reset_m_data", m_data, 0);
                check("reset_addr_read", addr_read, 0);
            end
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            if (done) done_cnt++;
            if (stall_prev) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, stall_data);
                check("stall_last", m_last, stall_last);
            end
            if (exp_q.size() == 0) check("valid_without_expected_beat", m_valid, 0);
            if (lat_armed) begin
                lat_cnt++;
                if (m_valid || lat_cnt > 3) begin
                    check("first_valid_latency", lat_cnt, 3);
                    lat_armed = 1'b0;
                end
            end
            next_busy = exp_busy;
            next_done = 1'b0;
            if (m_valid && m_ready && exp_q.size() > 0) begin
                b = exp_q.pop_front();
                check("beat_data", m_data, b.data);
                check("beat_last", m_last, b.last);
                if (xfer_beats == 0) begin
                    xfer_first     = m_data;
                    xfer_first_cyc = cyc;
                end
                xfer_beats++;
                if (b.last) begin
                    xfer_lastd    = m_data;
                    xfer_last_cyc = cyc;
                    next_busy     = 1'b0;
                    next_done     = 1'b1;
                end
            end
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
            stall_last = m_last;
            if (start && !exp_busy) begin
                clamp      = (int'(len) > DEPTH) ? DEPTH : int'(len);
                xfer_beats = 0;
                if (clamp == 0) begin
                    next_done = 1'b1;
                end else begin
                    next_busy = 1'b1;
                    for (int k = 0; k < clamp; k++)
                        exp_q.push_back('{data: mem[(int'(base) + k) % DEPTH], last: (k == clamp - 1)});
                    lat_armed = 1'b1;
                    lat_cnt   = 0;
                end
            end
            exp_busy = next_busy;
            exp_done = next_done;
            rst_prev = 1'b0;
        end
    end

    function automatic logic ready_for(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 3 == 0);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic wait_done(input int d0, input int mode, input int k0);
        logic timed_out = 1'b1;
        int   k = k0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (done_cnt != d0) begin
                timed_out = 1'b0;
                break;
            end
            m_ready = ready_for(mode, k++);
        end
        check("done_timeout", timed_out, 0);
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_xfer(input int b_in, input int l_in, input int mode);
        int d0 = done_cnt;
        @(negedge clk);
        start   = 1'b1;
        base    = ADDRW'(b_in);
        len     = LENW'(l_in);
        m_ready = ready_for(mode, 0);
        @(negedge clk);
        start   = 1'b0;
        m_ready = ready_for(mode, 1);
        wait_done(d0, mode, 2);
    endtask

    typedef struct {
        int base;
        int len;
        int mode;
        int beats;
        int first;
        int lastd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int d0, l;
        for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i);
        vecs[0] = '{16,  4,   0, 4,   16,  19};
        vecs[1] = '{254, 4,   0, 4,   254, 1};
        vecs[2] = '{0,   8,   1, 8,   0,   7};
        vecs[3] = '{0,   8,   2, 8,   0,   7};
        vecs[4] = '{0,   0,   0, 0,   0,   0};
        vecs[5] = '{77,  1,   0, 1,   77,  77};
        vecs[6] = '{0,   300, 0, 256, 0,   255};
        vecs[7] = '{200, 256, 2, 256, 200, 199};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            run_xfer(vecs[i].base, vecs[i].len, vecs[i].mode);
            check("vec_beats", xfer_beats, vecs[i].beats);
            if (vecs[i].beats > 0) begin
                check("vec_first", xfer_first, vecs[i].first);
                check("vec_last", xfer_lastd, vecs[i].lastd);
            end
            if (vecs[i].mode == 0 && vecs[i].beats > 1)
                check("vec_throughput", xfer_last_cyc - xfer_first_cyc, vecs[i].beats - 1);
            $display("vector %0d: base=%0d len=%0d beats=%0d", i, vecs[i].base, vecs[i].len, xfer_beats);
        end

        // start pulsed while busy must leave the running transfer untouched
        d0 = done_cnt;
        @(negedge clk); start = 1'b1; base = 8'd40; len = 9'd6; m_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); start = 1'b1; base = 8'd100; len = 9'd2;
        @(negedge clk); start = 1'b0;
        wait_done(d0, 0, 0);
        repeat (8) @(negedge clk);
        check("busy_start_beats", xfer_beats, 6);
        check("busy_start_first", xfer_first, 40);
        check("busy_start_last", xfer_lastd, 45);
        check("busy_start_done_count", done_cnt - d0, 1);
        $display("busy-start sequence: beats=%0d first=%0d last=%0d", xfer_beats, xfer_first, xfer_lastd);

        // reset with the buffer full and reads pending
        d0 = done_cnt;
        @(negedge clk); start = 1'b1; base = 8'd0; len = 9'd8; m_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; m_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("reset_no_done", done_cnt - d0, 0);
        m_ready = 1'b0;
        run_xfer(5, 2, 0);
        check("post_reset_beats", xfer_beats, 2);
        check("post_reset_first", xfer_first, 5);
        check("post_reset_last", xfer_lastd, 6);
        $display("mid-transfer reset sequence: beats=%0d first=%0d last=%0d", xfer_beats, xfer_first, xfer_lastd);

        for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
        for (int n = 0; n < 25; n++) begin
            int bb;
            bb = $urandom_range(0, DEPTH - 1);
            l  = ($urandom_range(0, 9) == 0) ? 300 : $urandom_range(0, 12);
            run_xfer(bb, l, 2);
            check("rand_beats", xfer_beats, (l > DEPTH) ? DEPTH : l);
            $display("random %0d: base=%0d len=%0d beats=%0d", n, bb, l, xfer_beats);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
